// File: rtl/arbitro_rr_param_pkg.sv
// Shared definitions for the round-robin FIFO-to-FIFO arbiter.
// Holds the default channel count and data width, the arbitration mode
// encoding, and a constant-foldable ceil(log2) helper.
package arbitro_rr_param_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int DW_DEFAULT  = 10;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/arbitro_rr_param_if.sv
// Bus bundle for the arbiter.
//   mode        : 0 fixed priority, 1 round robin
//   empty       : per-source FIFO empty flags
//   data_poped  : per-source show-ahead head words, source i at [i*DW +: DW]
//   alm_full    : per-destination almost-full flags
//   pop / push  : one-hot-or-zero strobes to source / destination FIFOs
//   data_pushed : per-destination data, destination j at [j*DW +: DW]
//   idle        : nothing popped this cycle and no push pending
//   xfer_count  : completed pushes since reset, wrapping
// master = environment side, slave = arbiter side.
interface arbitro_rr_param_if #(
    parameter int NCH = arbitro_rr_param_pkg::NCH_DEFAULT,
    parameter int DW  = arbitro_rr_param_pkg::DW_DEFAULT
);
    logic                mode;
    logic [NCH-1:0]      empty;
    logic [NCH*DW-1:0]   data_poped;
    logic [NCH-1:0]      alm_full;
    logic [NCH-1:0]      pop;
    logic [NCH-1:0]      push;
    logic [NCH*DW-1:0]   data_pushed;
    logic                idle;
    logic [15:0]         xfer_count;

    modport master (
        output mode, empty, data_poped, alm_full,
        input  pop, push, data_pushed, idle, xfer_count
    );

    modport slave (
        input  mode, empty, data_poped, alm_full,
        output pop, push, data_pushed, idle, xfer_count
    );
endinterface

// File: rtl/arbitro_rr_param_rr_priority_sel.sv
// Grant search: returns a one-hot grant for the first set request found
// scanning upward from start (round robin) or from index 0 (fixed
// priority), wrapping modulo NCH.
//   req   : request vector
//   start : first index examined in round-robin mode
//   mode  : arbitration mode
//   grant : one-hot-or-zero result
module rr_priority_sel
    import arbitro_rr_param_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int LW  = clog2_f(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [LW-1:0]  start,
    input  logic           mode,
    output logic [NCH-1:0] grant
);
    logic [LW-1:0] base;
    logic [LW-1:0] idx;
    logic          found;

    // NCH is a power of two, so the LW-bit add wraps modulo NCH for free.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        base  = (mode == MODE_RR) ? start : '0;
        for (int i = 0; i < NCH; i++) begin
            idx = base + LW'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbitro_rr_param.sv
// Routes words from NCH show-ahead source FIFOs to NCH destination FIFOs.
// The destination is the top log2(NCH) bits of each word. One source is
// granted per cycle (pop, combinational); the word is registered and
// pushed to its destination on the following cycle.
//   clk : sole clock
//   rst : asynchronous active-low reset
//   bus : arbitro_rr_param_if slave modport
module arbitro_rr_param
    import arbitro_rr_param_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int DW  = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    arbitro_rr_param_if.slave bus
);
    localparam int LW = clog2_f(NCH);

    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant;
    logic [LW-1:0]  grant_idx;
    logic [LW-1:0]  start_idx;
    logic [DW-1:0]  word_sel;

    logic           run_q, run_d;
    logic [LW-1:0]  last_grant_q, last_grant_d;
    logic           push_vld_q, push_vld_d;
    logic [LW-1:0]  push_dest_q, push_dest_d;
    logic [DW-1:0]  push_word_q, push_word_d;
    logic [15:0]    xfer_count_q, xfer_count_d;

    // run_q holds off pops until the first clock edge seen out of reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!bus.empty[i] && !bus.alm_full[bus.data_poped[i*DW + DW - 1 -: LW]])
                elig[i] = run_q;
        end
    end

    assign start_idx = last_grant_q + LW'(1);

    rr_priority_sel #(.NCH(NCH), .LW(LW)) u_sel (
        .req   (elig),
        .start (start_idx),
        .mode  (bus.mode),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) grant_idx = LW'(i);
        end
    end

    assign word_sel = bus.data_poped[grant_idx*DW +: DW];

    always_comb begin
        run_d        = 1'b1;
        last_grant_d = last_grant_q;
        push_vld_d   = |grant;
        push_dest_d  = push_dest_q;
        push_word_d  = push_word_q;
        xfer_count_d = xfer_count_q + {15'd0, push_vld_q};
        if (|grant) begin
            last_grant_d = grant_idx;
            push_word_d  = word_sel;
            push_dest_d  = word_sel[DW-1 -: LW];
        end
    end

    // A pending push always completes: alm_full is only consulted at pop time.
    always_comb begin
        bus.push        = '0;
        bus.data_pushed = '0;
        if (push_vld_q) begin
            bus.push[push_dest_q]                  = 1'b1;
            bus.data_pushed[push_dest_q*DW +: DW]  = push_word_q;
        end
    end

    assign bus.pop        = grant;
    assign bus.idle       = ~(|grant) & ~push_vld_q;
    assign bus.xfer_count = xfer_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q        <= 1'b0;
            last_grant_q <= LW'(NCH - 1);
            push_vld_q   <= 1'b0;
            push_dest_q  <= '0;
            push_word_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            run_q        <= run_d;
            last_grant_q <= last_grant_d;
            push_vld_q   <= push_vld_d;
            push_dest_q  <= push_dest_d;
            push_word_q  <= push_word_d;
            xfer_count_q <= xfer_count_d;
        end
    end
endmodule

// File: tb/tb_arbitro_rr_param.sv
// Testbench for arbitro_rr_param (NCH=4, DW=10): a vector table for the
// directed arbitration scenarios, randomized traffic against a reference
// model, and hand sequences for reset-while-pending and counter wrap.
module tb_arbitro_rr_param;
    localparam int NCH = 4;
    localparam int DW  = 10;
    localparam int LW  = 2;

    logic clk;
    logic rst_drv;

    arbitro_rr_param_if #(.NCH(NCH), .DW(DW)) bus ();

    arbitro_rr_param #(.NCH(NCH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst_drv),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_run;
    int          m_last;
    bit          m_pend;
    int          m_pdest;
    logic [DW-1:0] m_pword;
    int unsigned m_cnt;

    // sampled DUT outputs
    logic [NCH-1:0]    s_pop, s_push;
    logic [NCH*DW-1:0] s_dp;
    logic              s_idle;
    logic [15:0]       s_xfer;

    typedef struct {
        logic           mode;
        logic [3:0]     empty;
        logic [3:0]     alm;
        logic [39:0]    data;
        logic [3:0]     pop;
        logic [3:0]     push;
        logic [39:0]    dp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int c);
        logic [NCH*DW-1:0] d;
        d = bus.data_poped;
        return d[c*DW +: DW];
    endfunction

    function automatic int dest_of(input logic [DW-1:0] w);
        return int'(w) / (1 << (DW - LW));
    endfunction

    function automatic logic [39:0] dpv(input int d, input logic [9:0] w);
        return 40'(w) << (d * DW);
    endfunction

    task automatic step(input bit do_chk);
        int g;
        int c;
        logic [63:0] e_pop, e_push, e_dp;
        @(negedge clk);
        if (!rst_drv) begin
            m_run = 0; m_last = NCH - 1; m_pend = 0; m_cnt = 0;
        end
        g = -1;
        if (rst_drv && m_run) begin
            for (int k = 0; k < NCH; k++) begin
                c = bus.mode ? (m_last + 1 + k) % NCH : k;
                if (g < 0 && !bus.empty[c] && !bus.alm_full[dest_of(word_of(c))]) g = c;
            end
        end
        e_pop  = (g >= 0) ? (64'd1 << g) : 64'd0;
        e_push = m_pend ? (64'd1 << m_pdest) : 64'd0;
        e_dp   = m_pend ? (64'(m_pword) << (m_pdest * DW)) : 64'd0;
        s_pop = bus.pop; s_push = bus.push; s_dp = bus.data_pushed;
        s_idle = bus.idle; s_xfer = bus.xfer_count;
        if (do_chk) begin
            chk("pop", 64'(s_pop), e_pop);
            chk("push", 64'(s_push), e_push);
            chk("data_pushed", 64'(s_dp), e_dp);
            chk("idle", 64'(s_idle), 64'((g < 0) && !m_pend));
            chk("xfer_count", 64'(s_xfer), 64'(m_cnt));
        end
        if (rst_drv) begin
            m_cnt = (m_cnt + (m_pend ? 1 : 0)) & 32'hFFFF;
            m_pend = (g >= 0);
            if (g >= 0) begin
                m_pword = word_of(g);
                m_pdest = dest_of(m_pword);
                m_last  = g;
            end
            m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        step(1);
        chk("rst_push", 64'(s_push), 64'd0);
        chk("rst_idle", 64'(s_idle), 64'd1);
        chk("rst_xfer", 64'(s_xfer), 64'd0);
        chk("rst_dp", 64'(s_dp), 64'd0);
        step(1);
        rst_drv = 1'b1;
        step(1);
        chk("no_pop_at_release", 64'(s_pop), 64'd0);
    endtask

    logic [39:0] d1, d2;

    initial begin
        d1 = {10'h3CC, 10'h2CC, 10'h1CC, 10'h0CC};
        d2 = {10'h3CC, 10'h2CC, 10'h0CD, 10'h0CC};
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, d1, 4'b0001, 4'b0000, 40'd0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, d1, 4'b0010, 4'b0001, dpv(0, 10'h0CC)};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, d1, 4'b0100, 4'b0010, dpv(1, 10'h1CC)};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, d1, 4'b1000, 4'b0100, dpv(2, 10'h2CC)};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, d1, 4'b0001, 4'b1000, dpv(3, 10'h3CC)};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, d1, 4'b0001, 4'b0001, dpv(0, 10'h0CC)};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, d1, 4'b0001, 4'b0001, dpv(0, 10'h0CC)};
        tbl[7]  = '{1'b1, 4'b0001, 4'b0000, d1, 4'b0010, 4'b0001, dpv(0, 10'h0CC)};
        tbl[8]  = '{1'b1, 4'b0001, 4'b0000, d1, 4'b0100, 4'b0010, dpv(1, 10'h1CC)};
        tbl[9]  = '{1'b1, 4'b0001, 4'b0000, d1, 4'b1000, 4'b0100, dpv(2, 10'h2CC)};
        tbl[10] = '{1'b1, 4'b0001, 4'b0000, d1, 4'b0010, 4'b1000, dpv(3, 10'h3CC)};
        tbl[11] = '{1'b1, 4'b0000, 4'b0011, d2, 4'b0100, 4'b0010, dpv(1, 10'h1CC)};
        tbl[12] = '{1'b1, 4'b0000, 4'b0001, d2, 4'b1000, 4'b0100, dpv(2, 10'h2CC)};
        tbl[13] = '{1'b1, 4'b0000, 4'b0001, d2, 4'b0100, 4'b1000, dpv(3, 10'h3CC)};
        tbl[14] = '{1'b1, 4'b0000, 4'b0001, d2, 4'b1000, 4'b0100, dpv(2, 10'h2CC)};
        tbl[15] = '{1'b1, 4'b0000, 4'b0000, d2, 4'b0001, 4'b1000, dpv(3, 10'h3CC)};
        tbl[16] = '{1'b1, 4'b0000, 4'b0000, d2, 4'b0010, 4'b0001, dpv(0, 10'h0CC)};
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, d2, 4'b0100, 4'b0001, dpv(0, 10'h0CD)};

        rst_drv = 1'b0;
        bus.mode = 1'b1;
        bus.empty = '0;
        bus.alm_full = '0;
        bus.data_poped = d1;
        m_run = 0; m_last = NCH - 1; m_pend = 0; m_cnt = 0; m_pdest = 0; m_pword = '0;

        do_reset();

        // directed table
        for (int i = 0; i < 18; i++) begin
            bus.mode = tbl[i].mode;
            bus.empty = tbl[i].empty;
            bus.alm_full = tbl[i].alm;
            bus.data_poped = tbl[i].data;
            step(1);
            chk($sformatf("tbl%0d_pop", i), 64'(s_pop), 64'(tbl[i].pop));
            chk($sformatf("tbl%0d_push", i), 64'(s_push), 64'(tbl[i].push));
            chk($sformatf("tbl%0d_dp", i), 64'(s_dp), 64'(tbl[i].dp));
            chk($sformatf("tbl%0d_idle", i), 64'(s_idle), 64'd0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_drv = ($urandom_range(0, 99) != 0);
            bus.mode = 1'($urandom_range(0, 1));
            bus.empty = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.alm_full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.data_poped = {8'($urandom), 32'($urandom)};
            step(1);
        end

        // reset while a push is pending
        rst_drv = 1'b1;
        bus.mode = 1'b1; bus.empty = '0; bus.alm_full = '0; bus.data_poped = d1;
        step(1);
        step(1);
        chk("pend_before_rst", 64'(s_push != 0), 64'd1);
        rst_drv = 1'b0;
        step(1);
        chk("rst_mid_push", 64'(s_push), 64'd0);
        chk("rst_mid_xfer", 64'(s_xfer), 64'd0);
        chk("rst_mid_idle", 64'(s_idle), 64'd1);
        rst_drv = 1'b1;
        step(1);
        chk("release_no_pop", 64'(s_pop), 64'd0);
        chk("release_no_push", 64'(s_push), 64'd0);
        step(1);
        chk("first_pop_src0", 64'(s_pop), 64'd1);

        // xfer_count wrap
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            if (m_cnt == 32'hFFFF) break;
            step(0);
        end
        step(1);
        chk("xfer_at_ffff", 64'(s_xfer), 64'hFFFF);
        step(1);
        chk("xfer_wrapped", 64'(s_xfer), 64'd0);
        chk("push_after_wrap", 64'(s_push != 0), 64'd1);
        step(1);
        chk("xfer_after_wrap", 64'(s_xfer), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
